// File: rtl/keccak_arbiter.sv
// Round-robin arbiter/sequencer sharing one keccak core among N_REQ requesters.
// The core must be reset by the same i_rstn so both sides restart in step.
module keccak_arbiter #(
  parameter int N_REQ = 3,
  parameter int GAP   = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [2*N_REQ-1:0]   i_mode,
  input  logic [11*N_REQ-1:0]  i_ibyte_len,
  input  logic [10*N_REQ-1:0]  i_obyte_len,
  input  logic [64*N_REQ-1:0]  i_ibytes,
  input  logic [N_REQ-1:0]     i_ibytes_valid,
  output logic [N_REQ-1:0]     o_ibytes_ready,
  output logic [N_REQ-1:0]     o_gnt,
  output logic [63:0]          o_obytes,
  output logic [N_REQ-1:0]     o_obytes_valid,
  output logic [N_REQ-1:0]     o_done,
  output logic [1:0]           o_k_mode,
  output logic [63:0]          o_k_ibytes,
  output logic                 o_k_ibytes_valid,
  output logic [10:0]          o_k_ibyte_len,
  output logic [9:0]           o_k_obyte_len,
  input  logic [63:0]          i_k_obytes,
  input  logic                 i_k_obytes_valid,
  input  logic                 i_k_ibytes_ready
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_BUSY  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]       state_reg;
  logic [IW-1:0]    ptr_reg;
  logic [IW-1:0]    idx_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic [1:0]       mode_reg;
  logic [10:0]      ilen_reg;
  logic [9:0]       olen_reg;
  logic [7:0]       out_words_reg;
  logic [7:0]       word_cnt_reg;
  logic [GW-1:0]    gap_cnt_reg;

  logic [1:0]  mode_arr   [N_REQ];
  logic [10:0] ilen_arr   [N_REQ];
  logic [9:0]  olen_arr   [N_REQ];
  logic [63:0] ibytes_arr [N_REQ];

  logic          busy;
  logic          found;
  logic [IW-1:0] win_idx;
  logic [10:0]   olen_eff;
  logic [7:0]    out_words_c;

  assign busy = (state_reg == S_BUSY);

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign mode_arr[gi]   = i_mode[2*gi +: 2];
    assign ilen_arr[gi]   = i_ibyte_len[11*gi +: 11];
    assign olen_arr[gi]   = i_obyte_len[10*gi +: 10];
    assign ibytes_arr[gi] = i_ibytes[64*gi +: 64];
    assign o_done[gi]     = (state_reg == S_DONE) && (idx_reg == IW'(gi));
  end

  // First pending request strictly after the pointer, wrapping around.
  always_comb begin
    int cand;
    cand    = 0;
    found   = 1'b0;
    win_idx = ptr_reg;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr_reg) + k) % N_REQ;
      if (!found && i_req[cand]) begin
        found   = 1'b1;
        win_idx = IW'(cand);
      end
    end
  end

  // SHA3 digests have fixed lengths; only SHAKE uses the requested length.
  always_comb begin
    olen_eff = {1'b0, olen_reg};
    if (mode_reg[1]) olen_eff = mode_reg[0] ? 11'd64 : 11'd32;
    out_words_c = 8'((olen_eff + 11'd7) >> 3);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= IW'(N_REQ - 1);
      idx_reg       <= '0;
      gnt_reg       <= '0;
      mode_reg      <= '0;
      ilen_reg      <= '0;
      olen_reg      <= '0;
      out_words_reg <= '0;
      word_cnt_reg  <= '0;
      gap_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (found) begin
            gnt_reg   <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            idx_reg   <= win_idx;
            ptr_reg   <= win_idx;
            mode_reg  <= mode_arr[win_idx];
            ilen_reg  <= ilen_arr[win_idx];
            olen_reg  <= olen_arr[win_idx];
            state_reg <= S_GRANT;
          end
        end
        S_GRANT: begin
          out_words_reg <= out_words_c;
          if (out_words_c == 8'd0) begin
            gnt_reg   <= '0;
            state_reg <= S_DONE;
          end else begin
            state_reg <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (i_k_obytes_valid) begin
            word_cnt_reg <= word_cnt_reg + 8'd1;
            if (word_cnt_reg + 8'd1 == out_words_reg) begin
              gnt_reg   <= '0;
              state_reg <= S_DONE;
            end
          end
        end
        S_DONE: begin
          word_cnt_reg <= '0;
          gap_cnt_reg  <= '0;
          state_reg    <= (GAP == 0) ? S_IDLE : S_GAP;
        end
        S_GAP: begin
          if (gap_cnt_reg == GW'(GAP - 1)) state_reg <= S_IDLE;
          else gap_cnt_reg <= gap_cnt_reg + GW'(1);
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign o_gnt            = gnt_reg;
  assign o_k_mode         = mode_reg;
  assign o_k_ibyte_len    = ilen_reg;
  assign o_k_obyte_len    = olen_reg;
  assign o_k_ibytes       = busy ? ibytes_arr[idx_reg] : '0;
  assign o_k_ibytes_valid = busy & i_ibytes_valid[idx_reg];
  assign o_ibytes_ready   = busy ? (gnt_reg & {N_REQ{i_k_ibytes_ready}}) : '0;
  assign o_obytes         = busy ? i_k_obytes : '0;
  assign o_obytes_valid   = busy ? (gnt_reg & {N_REQ{i_k_obytes_valid}}) : '0;

endmodule

// File: tb/tb_keccak_arbiter.sv
// Scoreboard bench for keccak_arbiter: stimulus queues expected grant/word/done
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_keccak_arbiter;

  localparam int N   = 3;
  localparam int GAP = 2;
  localparam int K_GNT = 0, K_WORD = 1, K_DONE = 2;

  logic          clk = 1'b0;
  logic          i_rstn;
  logic [N-1:0]  i_req;
  logic [2*N-1:0]  i_mode;
  logic [11*N-1:0] i_ibyte_len;
  logic [10*N-1:0] i_obyte_len;
  logic [64*N-1:0] i_ibytes;
  logic [N-1:0]  i_ibytes_valid;
  logic [N-1:0]  o_ibytes_ready;
  logic [N-1:0]  o_gnt;
  logic [63:0]   o_obytes;
  logic [N-1:0]  o_obytes_valid;
  logic [N-1:0]  o_done;
  logic [1:0]    o_k_mode;
  logic [63:0]   o_k_ibytes;
  logic          o_k_ibytes_valid;
  logic [10:0]   o_k_ibyte_len;
  logic [9:0]    o_k_obyte_len;
  logic [63:0]   i_k_obytes;
  logic          i_k_obytes_valid;
  logic          i_k_ibytes_ready;

  keccak_arbiter #(.N_REQ(N), .GAP(GAP)) dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_req(i_req), .i_mode(i_mode),
    .i_ibyte_len(i_ibyte_len), .i_obyte_len(i_obyte_len),
    .i_ibytes(i_ibytes), .i_ibytes_valid(i_ibytes_valid),
    .o_ibytes_ready(o_ibytes_ready), .o_gnt(o_gnt), .o_obytes(o_obytes),
    .o_obytes_valid(o_obytes_valid), .o_done(o_done), .o_k_mode(o_k_mode),
    .o_k_ibytes(o_k_ibytes), .o_k_ibytes_valid(o_k_ibytes_valid),
    .o_k_ibyte_len(o_k_ibyte_len), .o_k_obyte_len(o_k_obyte_len),
    .i_k_obytes(i_k_obytes), .i_k_obytes_valid(i_k_obytes_valid),
    .i_k_ibytes_ready(i_k_ibytes_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [2:0] vec;
    logic [63:0] data;
  } ev_t;

  ev_t  q[$];
  int   checks = 0;
  int   failures = 0;
  logic [N-1:0] prev_gnt = '0;

  function automatic logic [63:0] word_of(int r, int i);
    return 64'hC0DE_0000_0000_0000 | (64'(r) << 32) | 64'(i);
  endfunction

  task automatic push(int k, logic [2:0] v, logic [63:0] d);
    q.push_back('{kind: k, vec: v, data: d});
  endtask

  task automatic sb_check(int k, logic [2:0] v, logic [63:0] d, string name);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected: got vec=%b data=%h, required no event", name, v, d);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.vec != v || e.data != d) begin
        failures++;
        $display("FAIL %s: got kind=%0d vec=%b data=%h, required kind=%0d vec=%b data=%h",
                 name, k, v, d, e.kind, e.vec, e.data);
      end else if (k == K_DONE) begin
        $display("txn done: req=%b at %0t", v, $time);
      end
    end
  endtask

  always @(negedge clk) begin
    if (o_gnt != '0 && prev_gnt == '0) sb_check(K_GNT, o_gnt, 64'd0, "sb_gnt");
    if (o_obytes_valid != '0) sb_check(K_WORD, o_obytes_valid, o_obytes, "sb_word");
    if (o_done != '0) sb_check(K_DONE, o_done, 64'd0, "sb_done");
    prev_gnt <= o_gnt;
  end

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic set_cfg(int r, logic [1:0] m, int il, int ol);
    i_mode[2*r +: 2]       = m;
    i_ibyte_len[11*r +: 11] = 11'(il);
    i_obyte_len[10*r +: 10] = 10'(ol);
  endtask

  task automatic wait_gnt();
    int n;
    n = 0;
    while (o_gnt == '0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (o_gnt == '0) begin
      failures++;
      $display("FAIL wait_gnt: got no grant within %0d cycles, required a grant", n);
    end
  endtask

  task automatic drive_words(int r, int n, int exp_olen);
    for (int i = 0; i < n; i++) begin
      i_k_obytes       = word_of(r, i);
      i_k_obytes_valid = 1'b1;
      chk("k_obyte_len", 64'(o_k_obyte_len), 64'(exp_olen));
      tick();
    end
    i_k_obytes_valid = 1'b0;
  endtask

  task automatic chk_all_zero(string name);
    chk({name, "_gnt"}, 64'(o_gnt), 64'd0);
    chk({name, "_obytes"}, o_obytes, 64'd0);
    chk({name, "_kibytes"}, o_k_ibytes, 64'd0);
    chk({name, "_ctl"}, 64'({o_k_mode, o_k_ibyte_len, o_k_obyte_len, o_k_ibytes_valid,
                              o_ibytes_ready, o_obytes_valid, o_done}), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    i_rstn = 1'b0; i_req = '0; i_mode = '0; i_ibyte_len = '0; i_obyte_len = '0;
    i_ibytes = '0; i_ibytes_valid = '0; i_k_obytes = '0; i_k_obytes_valid = 1'b0;
    i_k_ibytes_ready = 1'b1;
    idle(2);
    i_rstn = 1'b1;
    tick();
    chk_all_zero("reset");

    // Three simultaneous SHA3-512 requests: order 0,1,2 with gaps between.
    for (int r = 0; r < N; r++) begin
      set_cfg(r, 2'b11, 64, 0);
      push(K_GNT, 3'(1 << r), 64'd0);
      for (int i = 0; i < 8; i++) push(K_WORD, 3'(1 << r), word_of(r, i));
      push(K_DONE, 3'(1 << r), 64'd0);
    end
    i_req = 3'b111;
    for (int r = 0; r < N; r++) begin
      wait_gnt();
      tick();
      drive_words(r, 8, 0);
      i_req[r] = 1'b0;
      if (r < N - 1) begin
        cnt = 0;
        tick();
        while (o_gnt == '0 && cnt < 30) begin
          cnt++;
          tick();
        end
        checks++;
        if (cnt < GAP) begin
          failures++;
          $display("FAIL gap_cycles: got %0d idle cycles, required at least %0d", cnt, GAP);
        end
      end
    end
    idle(GAP + 3);

    // SHA3-256 from requester 1 with input routing checks.
    set_cfg(1, 2'b10, 32, 0);
    i_ibytes[64 +: 64] = 64'h1111_2222_3333_4444;
    i_ibytes[0 +: 64]  = 64'h9999_8888_7777_6666;
    i_ibytes_valid = 3'b011;
    push(K_GNT, 3'b010, 64'd0);
    for (int i = 0; i < 4; i++) push(K_WORD, 3'b010, word_of(1, i));
    push(K_DONE, 3'b010, 64'd0);
    i_req[1] = 1'b1;
    tick();
    chk("gnt_latency", 64'(o_gnt), 64'(3'b010));
    tick();
    chk("k_mode", 64'(o_k_mode), 64'(2'b10));
    chk("k_ibyte_len", 64'(o_k_ibyte_len), 64'd32);
    chk("k_ibytes", o_k_ibytes, 64'h1111_2222_3333_4444);
    chk("k_ibytes_valid", 64'(o_k_ibytes_valid), 64'd1);
    chk("ibytes_ready", 64'(o_ibytes_ready), 64'(3'b010));
    drive_words(1, 4, 0);
    chk("done_sha256", 64'(o_done), 64'(3'b010));
    chk("gnt_cleared", 64'(o_gnt), 64'd0);
    i_req = '0;
    i_ibytes_valid = '0;
    idle(GAP + 3);

    // SHAKE128 from requester 0, 504 bytes -> 63 words.
    set_cfg(0, 2'b00, 16, 504);
    push(K_GNT, 3'b001, 64'd0);
    for (int i = 0; i < 63; i++) push(K_WORD, 3'b001, word_of(0, i));
    push(K_DONE, 3'b001, 64'd0);
    i_req[0] = 1'b1;
    wait_gnt();
    tick();
    drive_words(0, 63, 504);
    chk("done_shake128", 64'(o_done), 64'(3'b001));
    i_req = '0;
    idle(GAP + 3);

    // SHAKE256 with zero output length: no core activity.
    set_cfg(2, 2'b01, 8, 0);
    i_ibytes_valid[2] = 1'b1;
    push(K_GNT, 3'b100, 64'd0);
    push(K_DONE, 3'b100, 64'd0);
    i_req[2] = 1'b1;
    wait_gnt();
    chk("zero_kiv_grant", 64'(o_k_ibytes_valid), 64'd0);
    tick();
    chk("zero_done", 64'(o_done), 64'(3'b100));
    chk("zero_kiv_done", 64'(o_k_ibytes_valid), 64'd0);
    i_req = '0;
    i_ibytes_valid = '0;
    idle(GAP + 3);

    // SHAKE256, 33 bytes -> 5 words; a core valid during GRANT is dropped.
    set_cfg(1, 2'b01, 8, 33);
    push(K_GNT, 3'b010, 64'd0);
    for (int i = 0; i < 5; i++) push(K_WORD, 3'b010, word_of(1, i));
    push(K_DONE, 3'b010, 64'd0);
    i_req[1] = 1'b1;
    wait_gnt();
    i_k_obytes = 64'hDEAD;
    i_k_obytes_valid = 1'b1;
    chk("grant_valid_drop", 64'(o_obytes_valid), 64'd0);
    tick();
    drive_words(1, 5, 33);
    chk("done_shake33", 64'(o_done), 64'(3'b010));
    i_req = '0;
    idle(GAP + 3);

    // Reset in the middle of a BUSY transaction.
    set_cfg(0, 2'b00, 8, 80);
    push(K_GNT, 3'b001, 64'd0);
    for (int i = 0; i < 3; i++) push(K_WORD, 3'b001, word_of(0, i));
    i_req[0] = 1'b1;
    wait_gnt();
    tick();
    drive_words(0, 3, 80);
    i_k_obytes_valid = 1'b1;
    i_ibytes_valid = 3'b001;
    i_rstn = 1'b0;
    #1;
    chk_all_zero("midrst");
    i_k_obytes_valid = 1'b0;
    i_req = '0;
    tick();
    i_rstn = 1'b1;
    set_cfg(0, 2'b10, 32, 0);
    set_cfg(1, 2'b10, 32, 0);
    push(K_GNT, 3'b001, 64'd0);
    for (int i = 0; i < 4; i++) push(K_WORD, 3'b001, word_of(0, i));
    push(K_DONE, 3'b001, 64'd0);
    i_req = 3'b011;
    tick();
    chk("rst_first_gnt", 64'(o_gnt), 64'(3'b001));
    wait_gnt();
    tick();
    drive_words(0, 4, 0);
    i_req = '0;
    i_ibytes_valid = '0;
    idle(GAP + 3);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending events, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
